// File: rtl/serial_tx_scheduler.sv
// serial_tx_scheduler
// Round-robin scheduler for two parallel word sources sharing one serial pin.
// The granted word is loaded into a PISO shift register and sent MSB first.
// Each bit is held BIT_CYCLES clocks, and every frame is followed by GAP idle
// clocks. All outputs except the ready strobes come straight from flops.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a request; readies driven from the arbiter
// S_SHIFT | frame in progress, frame_o high, shreg MSB on serial_o
// S_GAP   | inter-frame idle time, no grant, serial line low

module serial_tx_scheduler #(
    parameter int N          = 8,
    parameter int BIT_CYCLES = 1,
    parameter int GAP        = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req0_valid_i,
    input  logic [N-1:0] req0_data_i,
    output logic         req0_ready_o,
    input  logic         req1_valid_i,
    input  logic [N-1:0] req1_data_i,
    output logic         req1_ready_o,
    output logic         serial_o,
    output logic         frame_o,
    output logic         src_o,
    output logic         busy_o,
    output logic         done_o
);

    localparam int BW = $clog2(N);
    localparam int HW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [BW-1:0] BIT_LOAD  = BW'(N - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(BIT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LOAD  = GW'((GAP > 0) ? (GAP - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_shreg;
    logic [BW-1:0]   r_bit;
    logic [HW-1:0]   r_hold;
    logic [GW-1:0]   r_gap;
    logic            r_last;
    logic            r_frame;
    logic            r_src;
    logic            r_busy;
    logic            r_done;

    logic            w_idle;
    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_hs;
    logic [N-1:0]    w_data;

    // Arbiter: a lone requester always wins; on a tie the one that did not
    // own the previous frame wins. Both grants are mutually exclusive.
    always_comb begin
        w_idle = (r_state == S_IDLE);
        w_gnt0 = req0_valid_i && (!req1_valid_i || r_last);
        w_gnt1 = req1_valid_i && (!req0_valid_i || !r_last);
        req0_ready_o = w_idle && w_gnt0;
        req1_ready_o = w_idle && w_gnt1;
        // ready already implies valid, so any ready is a handshake
        w_hs   = req0_ready_o || req1_ready_o;
        w_data = req1_ready_o ? req1_data_i : req0_data_i;
    end

    // Sequencer FSM with registered outputs; the word is captured only on
    // the handshake edge, so later source changes cannot disturb the frame.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_shreg <= '0;
            r_bit   <= '0;
            r_hold  <= '0;
            r_gap   <= '0;
            r_last  <= 1'b1;
            r_frame <= 1'b0;
            r_src   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_shreg <= w_data;
                        r_src   <= req1_ready_o;
                        r_last  <= req1_ready_o;
                        r_bit   <= BIT_LOAD;
                        r_hold  <= HOLD_LOAD;
                        r_frame <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_hold != '0) begin
                        r_hold <= r_hold - HW'(1);
                        // done_o must already be high while both counters sit at 0
                        r_done <= (r_bit == '0) && (r_hold == HW'(1));
                    end else if (r_bit != '0) begin
                        r_hold  <= HOLD_LOAD;
                        r_bit   <= r_bit - BW'(1);
                        r_shreg <= {r_shreg[N-2:0], 1'b0};
                        r_done  <= (r_bit == BW'(1)) && (BIT_CYCLES == 1);
                    end else begin
                        // last bit finished; shifting it out leaves the line at 0
                        r_shreg <= {r_shreg[N-2:0], 1'b0};
                        r_frame <= 1'b0;
                        if (GAP > 0) begin
                            r_gap   <= GAP_LOAD;
                            r_state <= S_GAP;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap - GW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign serial_o = r_shreg[N-1];
    assign frame_o  = r_frame;
    assign src_o    = r_src;
    assign busy_o   = r_busy;
    assign done_o   = r_done;

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Directed testbench for serial_tx_scheduler.
// dut_a: N=8, BIT_CYCLES=1, GAP=1.  dut_b: N=8, BIT_CYCLES=3, GAP=0.
// Observed vector order everywhere: {frame, serial, src, busy, done}.

module tb_serial_tx_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic       a_v0 = 1'b0, a_v1 = 1'b0, a_r0, a_r1;
    logic [7:0] a_d0 = 8'h00, a_d1 = 8'h00;
    logic       a_ser, a_frm, a_src, a_busy, a_done;

    logic       b_v0 = 1'b0, b_v1 = 1'b0, b_r0, b_r1;
    logic [7:0] b_d0 = 8'h00, b_d1 = 8'h00;
    logic       b_ser, b_frm, b_src, b_busy, b_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_tx_scheduler #(.N(8), .BIT_CYCLES(1), .GAP(1)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(a_v0), .req0_data_i(a_d0), .req0_ready_o(a_r0),
        .req1_valid_i(a_v1), .req1_data_i(a_d1), .req1_ready_o(a_r1),
        .serial_o(a_ser), .frame_o(a_frm), .src_o(a_src),
        .busy_o(a_busy), .done_o(a_done)
    );

    serial_tx_scheduler #(.N(8), .BIT_CYCLES(3), .GAP(0)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(b_v0), .req0_data_i(b_d0), .req0_ready_o(b_r0),
        .req1_valid_i(b_v1), .req1_data_i(b_d1), .req1_ready_o(b_r1),
        .serial_o(b_ser), .frame_o(b_frm), .src_o(b_src),
        .busy_o(b_busy), .done_o(b_done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        checks++;
        if ({a_frm, a_ser, a_src, a_busy, a_done} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_a got=%b exp=00000", {a_frm, a_ser, a_src, a_busy, a_done});
        end
        checks++;
        if ({b_frm, b_ser, b_src, b_busy, b_done} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_b got=%b exp=00000", {b_frm, b_ser, b_src, b_busy, b_done});
        end
        a_v0 = 1'b1;
        a_v1 = 1'b1;
        #1;
        checks++;
        if ({a_r1, a_r0} !== 2'b01) begin
            failures++;
            $display("FAIL reset_tie_grant got=%b exp=01", {a_r1, a_r0});
        end
        a_v0 = 1'b0;
        a_v1 = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_single;
        logic [7:0] w = 8'hA5;
        a_d0 = w;
        a_v0 = 1'b1;
        #1;
        checks++;
        if ({a_r1, a_r0} !== 2'b01) begin
            failures++;
            $display("FAIL single_ready got=%b exp=01", {a_r1, a_r0});
        end
        tick;
        a_v0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({a_frm, a_ser, a_src, a_busy, a_done} !== {1'b1, w[7-i], 1'b0, 1'b1, (i == 7)}) begin
                failures++;
                $display("FAIL single_bit%0d got=%b exp=%b", i,
                         {a_frm, a_ser, a_src, a_busy, a_done}, {1'b1, w[7-i], 1'b0, 1'b1, (i == 7)});
            end
            tick;
        end
        checks++;
        if ({a_frm, a_ser, a_src, a_busy, a_done} !== 5'b00010) begin
            failures++;
            $display("FAIL single_gap got=%b exp=00010", {a_frm, a_ser, a_src, a_busy, a_done});
        end
        a_v0 = 1'b1;
        #1;
        checks++;
        if (a_r0 !== 1'b0) begin
            failures++;
            $display("FAIL single_gap_ready got=%b exp=0", a_r0);
        end
        a_v0 = 1'b0;
        tick;
        checks++;
        if ({a_frm, a_ser, a_src, a_busy, a_done} !== 5'b00000) begin
            failures++;
            $display("FAIL single_idle got=%b exp=00000", {a_frm, a_ser, a_src, a_busy, a_done});
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] w;
        logic       e;
        a_d0 = 8'h0F;
        a_d1 = 8'hF0;
        a_v0 = 1'b1;
        a_v1 = 1'b1;
        for (int f = 0; f < 4; f++) begin
            e = f[0];
            w = e ? 8'hF0 : 8'h0F;
            #1;
            checks++;
            if ({a_r1, a_r0} !== {e, ~e}) begin
                failures++;
                $display("FAIL b2b_grant%0d got=%b exp=%b", f, {a_r1, a_r0}, {e, ~e});
            end
            tick;
            for (int i = 0; i < 8; i++) begin
                checks++;
                if ({a_frm, a_ser, a_src, a_busy, a_done} !== {1'b1, w[7-i], e, 1'b1, (i == 7)}) begin
                    failures++;
                    $display("FAIL b2b_f%0d_bit%0d got=%b exp=%b", f, i,
                             {a_frm, a_ser, a_src, a_busy, a_done}, {1'b1, w[7-i], e, 1'b1, (i == 7)});
                end
                tick;
            end
            checks++;
            if ({a_frm, a_ser, a_src, a_busy, a_done, a_r1, a_r0} !== {2'b00, e, 4'b1000}) begin
                failures++;
                $display("FAIL b2b_gap%0d got=%b exp=%b", f,
                         {a_frm, a_ser, a_src, a_busy, a_done, a_r1, a_r0}, {2'b00, e, 4'b1000});
            end
            tick;
        end
        a_v0 = 1'b0;
        a_v1 = 1'b0;
    endtask

    task automatic test_single_req1;
        logic [7:0] w = 8'h81;
        a_d1 = w;
        a_v1 = 1'b1;
        for (int f = 0; f < 3; f++) begin
            #1;
            checks++;
            if ({a_r1, a_r0} !== 2'b10) begin
                failures++;
                $display("FAIL req1_grant%0d got=%b exp=10", f, {a_r1, a_r0});
            end
            tick;
            for (int i = 0; i < 8; i++) begin
                checks++;
                if ({a_frm, a_ser, a_src, a_busy, a_done} !== {1'b1, w[7-i], 1'b1, 1'b1, (i == 7)}) begin
                    failures++;
                    $display("FAIL req1_f%0d_bit%0d got=%b exp=%b", f, i,
                             {a_frm, a_ser, a_src, a_busy, a_done}, {1'b1, w[7-i], 1'b1, 1'b1, (i == 7)});
                end
                tick;
            end
            checks++;
            if ({a_frm, a_ser, a_src, a_busy, a_done} !== 5'b00110) begin
                failures++;
                $display("FAIL req1_gap%0d got=%b exp=00110", f, {a_frm, a_ser, a_src, a_busy, a_done});
            end
            tick;
        end
        a_v1 = 1'b0;
    endtask

    task automatic test_data_hold;
        logic [7:0] w = 8'h3C;
        a_d0 = w;
        a_v0 = 1'b1;
        #1;
        checks++;
        if ({a_r1, a_r0} !== 2'b01) begin
            failures++;
            $display("FAIL hold_ready got=%b exp=01", {a_r1, a_r0});
        end
        tick;
        a_v0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a_d0 = 8'($urandom);
            a_d1 = 8'($urandom);
            checks++;
            if ({a_frm, a_ser, a_src, a_busy, a_done} !== {1'b1, w[7-i], 1'b0, 1'b1, (i == 7)}) begin
                failures++;
                $display("FAIL hold_bit%0d got=%b exp=%b", i,
                         {a_frm, a_ser, a_src, a_busy, a_done}, {1'b1, w[7-i], 1'b0, 1'b1, (i == 7)});
            end
            tick;
        end
        tick;
    endtask

    task automatic test_bit_cycles;
        logic [7:0] w = 8'hC3;
        b_d0 = w;
        b_v0 = 1'b1;
        #1;
        checks++;
        if ({b_r1, b_r0} !== 2'b01) begin
            failures++;
            $display("FAIL bc3_ready got=%b exp=01", {b_r1, b_r0});
        end
        tick;
        for (int i = 0; i < 24; i++) begin
            checks++;
            if ({b_frm, b_ser, b_src, b_busy, b_done} !== {1'b1, w[7-i/3], 1'b0, 1'b1, (i == 23)}) begin
                failures++;
                $display("FAIL bc3_cyc%0d got=%b exp=%b", i,
                         {b_frm, b_ser, b_src, b_busy, b_done}, {1'b1, w[7-i/3], 1'b0, 1'b1, (i == 23)});
            end
            if (i == 0) begin
                checks++;
                if (b_r0 !== 1'b0) begin
                    failures++;
                    $display("FAIL bc3_ready_in_frame got=%b exp=0", b_r0);
                end
            end
            tick;
        end
        checks++;
        if ({b_frm, b_ser, b_src, b_busy, b_done, b_r0} !== 6'b000001) begin
            failures++;
            $display("FAIL bc3_next_ready got=%b exp=000001", {b_frm, b_ser, b_src, b_busy, b_done, b_r0});
        end
        b_v0 = 1'b0;
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] w = 8'h5A;
        a_d1 = 8'hFF;
        a_v1 = 1'b1;
        #1;
        checks++;
        if ({a_r1, a_r0} !== 2'b10) begin
            failures++;
            $display("FAIL rstmid_ready got=%b exp=10", {a_r1, a_r0});
        end
        tick;
        a_v1 = 1'b0;
        for (int i = 0; i < 4; i++) tick;
        checks++;
        if ({a_frm, a_ser, a_src, a_busy, a_done} !== 5'b11110) begin
            failures++;
            $display("FAIL rstmid_pre got=%b exp=11110", {a_frm, a_ser, a_src, a_busy, a_done});
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({a_frm, a_ser, a_src, a_busy, a_done} !== 5'b00000) begin
            failures++;
            $display("FAIL rstmid_async got=%b exp=00000", {a_frm, a_ser, a_src, a_busy, a_done});
        end
        tick;
        tick;
        rst = 1'b0;
        a_d0 = w;
        a_d1 = 8'h33;
        a_v0 = 1'b1;
        a_v1 = 1'b1;
        #1;
        checks++;
        if ({a_r1, a_r0} !== 2'b01) begin
            failures++;
            $display("FAIL rstmid_grant got=%b exp=01", {a_r1, a_r0});
        end
        tick;
        a_v0 = 1'b0;
        a_v1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({a_frm, a_ser, a_src, a_busy, a_done} !== {1'b1, w[7-i], 1'b0, 1'b1, (i == 7)}) begin
                failures++;
                $display("FAIL rstmid_bit%0d got=%b exp=%b", i,
                         {a_frm, a_ser, a_src, a_busy, a_done}, {1'b1, w[7-i], 1'b0, 1'b1, (i == 7)});
            end
            tick;
        end
        tick;
        checks++;
        if ({a_frm, a_ser, a_src, a_busy, a_done} !== 5'b00000) begin
            failures++;
            $display("FAIL rstmid_idle got=%b exp=00000", {a_frm, a_ser, a_src, a_busy, a_done});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        tick;
        test_reset;
        test_single;
        test_reset;
        test_back_to_back;
        test_single_req1;
        test_data_hold;
        test_bit_cycles;
        test_reset_mid_frame;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_tx_scheduler.md
# serial_tx_scheduler

Two-requester transmit scheduler for the shared serial line. It arbitrates round-robin between two parallel word sources and loads the granted word into an internal N-bit parallel-in/serial-out shift register. It then sequences the shift, MSB first, with a frame strobe, a per-bit hold time and an inter-frame gap. It sits between the parallel producers and the single serial output pin.

## Interface
- N, 8: word width in bits; N ≥ 2
- BIT_CYCLES, 1: clocks each bit is held on serial_o; ≥ 1
- GAP, 1: idle clocks inserted after every frame before the next grant; ≥ 0

- clk_i  input  1  clock; all state changes on rising edge
- rst_i  input  1  asynchronous, active-high reset
- req0_valid_i  input  1  requester 0 has a word
- req0_data_i  input  N  requester 0 word
- req0_ready_o  output  1  requester 0 word accepted this cycle when valid is high
- req1_valid_i  input  1  requester 1 has a word
- req1_data_i  input  N  requester 1 word
- req1_ready_o  output  1  requester 1 word accepted this cycle when valid is high
- serial_o  output  1  serial data, MSB first; 0 outside a frame
- frame_o  output  1  high for every bit cycle of a frame
- src_o  output  1  owner of the current or last frame (0/1)
- busy_o  output  1  high in SHIFT and GAP states
- done_o  output  1  one-clock pulse on the final clock of the last bit

## Operation
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - Grant is computed combinationally from valids and the round-robin pointer `last`.
  - If only one request is valid, that requester is granted.
  - If both are valid, the requester ≠ `last` is granted.
  - reqX_ready_o = (state==IDLE) && granted==X. At most one ready is high in any cycle.
  - On handshake (valid && ready): shreg ← data, src_o ← X, last ← X, bit counter ← N-1, hold counter ← BIT_CYCLES-1, next state SHIFT.
- SHIFT:
  - serial_o = shreg[N-1]; frame_o = 1.
  - Hold counter decrements each clock. At 0 it reloads, shreg shifts left by one with 0 filled in, and the bit counter decrements.
  - When bit counter == 0 and hold counter == 0: done_o = 1 for that clock, then next state is GAP (GAP>0) or IDLE (GAP==0).
- GAP: serial_o = 0, frame_o = 0, both readies low. After GAP clocks, next state is IDLE.
- Input data is sampled only on the handshake edge. Later changes on reqX_data_i do not affect the frame in progress.
- A valid input deasserted before grant is never transmitted. No requester is penalised for being idle; the arbiter is work-conserving.
- Counter widths: bit counter is clog2(N) bits; hold counter is clog2(BIT_CYCLES) bits, minimum 1; gap counter is clog2(GAP) bits, minimum 1.

## Timing
- Reset values: state IDLE, shreg 0, serial_o 0, frame_o 0, busy_o 0, done_o 0, src_o 0, last = 1 (so requester 0 wins the first tie).
- Reset is asynchronous. Outputs go to their reset values immediately, even mid-frame. The accepted word is discarded and never resumed.
- Outputs serial_o, frame_o, busy_o, done_o and src_o are registered. reqX_ready_o is combinational from state, last and valids.
- Handshake on edge k:
  - frame_o is high for clocks k+1 … k+N·BIT_CYCLES.
  - done_o is high on clock k+N·BIT_CYCLES.
  - GAP clocks follow.
  - The earliest next handshake is on clock k+N·BIT_CYCLES+GAP+1.
- Frame period with continuous requests: N·BIT_CYCLES+GAP+1 clocks.
- Requests that arrive during SHIFT or GAP wait. The arbitration decision uses the valids present in the first IDLE cycle.
- A request is never accepted during the reset-release cycle while rst_i is high.

## Test plan
- N=8, BIT_CYCLES=1, GAP=1; req0 sends 0xA5 alone -> req0_ready_o high for one cycle; serial_o = 1,0,1,0,0,1,0,1 over the next 8 clocks; frame_o high for 8 clocks; src_o=0; done_o on the 8th clock; 1 gap clock; serial_o 0 afterwards.
- Both valid continuously, req0=0x0F, req1=0xF0 -> grants alternate 0,1,0,1 starting with 0; frames are back-to-back every 10 clocks; each frame's bits match its source's data.
- Only req1 valid continuously with 0x81 -> req1 is granted every slot; src_o stays 1; no idle slots beyond GAP.
- BIT_CYCLES=3, GAP=0, word 0xC3 -> each bit is held 3 clocks; frame_o is high for 24 clocks; the next ready is high on the clock right after done_o.
- Reset asserted mid-frame after 4 bits -> serial_o, frame_o and busy_o drop to 0 immediately. After release, with both valid, req0 is granted first and its new word is sent complete.
- reqX_data_i changed every clock after the handshake -> the transmitted bits equal the value sampled at the handshake edge.
